// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the default operand width.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Code 2'd3 is unused and decodes to IDLE in the FSM default branch
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Operand magnitude/sign capture, shift-add accumulation and the product register.
// Driven by load/step/finish strobes from the controlling FSM.
module seq_multiplier_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] product,
  output logic               b_zero,
  output logic               cnt_end
);

  localparam int CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Operand magnitudes; the most negative value maps onto its unsigned magnitude exactly
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[WIDTH-1]) begin
      a_mag = -a;
    end else begin
      a_mag = a;
    end
    if (signed_mode && b[WIDTH-1]) begin
      b_mag = -b;
    end else begin
      b_mag = b;
    end
  end

  assign b_zero  = (b_reg == {WIDTH{1'b0}});
  assign cnt_end = (cnt == CW'(WIDTH));

  // Working registers and product; the product only changes on finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= {(2*WIDTH){1'b0}};
      b_reg   <= {WIDTH{1'b0}};
      acc     <= {(2*WIDTH){1'b0}};
      cnt     <= {CW{1'b0}};
      neg     <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
    end else if (load) begin
      a_reg <= {{WIDTH{1'b0}}, a_mag};
      b_reg <= b_mag;
      acc   <= {(2*WIDTH){1'b0}};
      cnt   <= {CW{1'b0}};
      neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      if (b_reg[0]) begin
        acc <= acc + a_reg;
      end else begin
        acc <= acc;
      end
      a_reg <= {a_reg[2*WIDTH-2:0], 1'b0};
      b_reg <= {1'b0, b_reg[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end else if (finish) begin
      product <= neg ? -acc : acc;
    end else begin
      product <= product;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier top: IDLE/CALC/DONE Moore FSM with valid/ack handshake,
// driving the datapath strobes. busy/done are registered decodes of the next state.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_data,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   step;
  logic   finish;
  logic   b_zero;
  logic   cnt_end;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_data) begin
          state_next = CALC;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (b_zero || cnt_end) begin
          state_next = DONE;
          finish     = 1'b1;
        end else begin
          state_next = CALC;
          step       = 1'b1;
        end
      end
      DONE: begin
        if (ack) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags track the state register one-for-one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == CALC);
      done <= (state_next == DONE);
    end
  end

  seq_multiplier_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .product    (product),
    .b_zero     (b_zero),
    .cnt_end    (cnt_end)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks on an 8-bit instance plus a randomised 32-bit regression
// against a reference product and latency model.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        valid8, sm8, ack8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        valid32, sm32, ack32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int n_checks;
  int n_fail;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .valid_data(valid8), .a(a8), .b(b8),
    .signed_mode(sm8), .ack(ack8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .valid_data(valid32), .a(a32), .b(b32),
    .signed_mode(sm32), .ack(ack32), .busy(busy32), .done(done32), .product(prod32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request; lat = edges from the sampling edge to done (-1 on timeout)
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                      output logic [15:0] p, output int lat, output int bcnt);
    @(negedge clk);
    a8 = ta; b8 = tb; sm8 = tsm; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (done8) begin
        lat = i;
      end else begin
        if (busy8) bcnt++;
        @(posedge clk); #1;
      end
    end
    p = prod8;
  endtask

  task automatic ack_done8();
    valid8 = 1'b0;
    ack8 = 1'b1;
    @(posedge clk); #1;
    ack8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 3;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy8); end
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done8); end
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h, expected 0000", prod8); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [15:0] p;
    int lat, bc;
    run8(8'd13, 8'd11, 1'b0, p, lat, bc);
    n_checks += 3;
    if (p !== 16'h008F) begin n_fail++; $display("FAIL u13x11_product: got %h, expected 008f", p); end
    if (lat != 5) begin n_fail++; $display("FAIL u13x11_latency: got %0d, expected 5", lat); end
    if (bc != 5) begin n_fail++; $display("FAIL u13x11_busy: got %0d, expected 5", bc); end
    ack_done8();
  endtask

  task automatic test_boundaries();
    logic [15:0] p;
    int lat, bc;
    run8(8'd255, 8'd0, 1'b0, p, lat, bc);
    n_checks += 3;
    if (p !== 16'h0000) begin n_fail++; $display("FAIL bzero_product: got %h, expected 0000", p); end
    if (lat != 1) begin n_fail++; $display("FAIL bzero_latency: got %0d, expected 1", lat); end
    if (bc != 1) begin n_fail++; $display("FAIL bzero_busy: got %0d, expected 1", bc); end
    ack_done8();
    run8(8'd255, 8'd255, 1'b0, p, lat, bc);
    n_checks += 2;
    if (p !== 16'hFE01) begin n_fail++; $display("FAIL max_product: got %h, expected fe01", p); end
    if (lat != 9) begin n_fail++; $display("FAIL max_latency: got %0d, expected 9", lat); end
    ack_done8();
  endtask

  task automatic test_signed();
    logic [15:0] p;
    int lat, bc;
    run8(8'h80, 8'h80, 1'b1, p, lat, bc);
    n_checks += 2;
    if (p !== 16'h4000) begin n_fail++; $display("FAIL s_min_min_product: got %h, expected 4000", p); end
    if (lat != 9) begin n_fail++; $display("FAIL s_min_min_latency: got %0d, expected 9", lat); end
    ack_done8();
    run8(8'hFD, 8'h05, 1'b1, p, lat, bc);
    n_checks += 2;
    if (p !== 16'hFFF1) begin n_fail++; $display("FAIL s_m3x5_product: got %h, expected fff1", p); end
    if (lat != 4) begin n_fail++; $display("FAIL s_m3x5_latency: got %0d, expected 4", lat); end
    ack_done8();
    // |b| = 1, so early termination leaves a two-cycle latency
    run8(8'h07, 8'hFF, 1'b1, p, lat, bc);
    n_checks += 2;
    if (p !== 16'hFFF9) begin n_fail++; $display("FAIL s_7xm1_product: got %h, expected fff9", p); end
    if (lat != 2) begin n_fail++; $display("FAIL s_7xm1_latency: got %0d, expected 2", lat); end
    ack_done8();
  endtask

  task automatic test_hold();
    logic [15:0] p;
    int lat, bc;
    run8(8'd3, 8'd4, 1'b0, p, lat, bc);
    n_checks += 1;
    if (p !== 16'd12) begin n_fail++; $display("FAIL hold_first_product: got %h, expected 000c", p); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid8 = (i % 2 == 0) ? 1'b1 : 1'b0;
      a8 = 8'd9 + 8'(i);
      b8 = 8'd9;
      @(posedge clk); #1;
      n_checks += 3;
      if (done8 !== 1'b1) begin n_fail++; $display("FAIL hold_done[%0d]: got %b, expected 1", i, done8); end
      if (busy8 !== 1'b0) begin n_fail++; $display("FAIL hold_busy[%0d]: got %b, expected 0", i, busy8); end
      if (prod8 !== 16'd12) begin n_fail++; $display("FAIL hold_product[%0d]: got %h, expected 000c", i, prod8); end
    end
    ack_done8();
    n_checks += 2;
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL hold_ack_done: got %b, expected 0", done8); end
    if (prod8 !== 16'd12) begin n_fail++; $display("FAIL hold_idle_product: got %h, expected 000c", prod8); end
    run8(8'd5, 8'd6, 1'b0, p, lat, bc);
    n_checks += 2;
    if (p !== 16'd30) begin n_fail++; $display("FAIL hold_next_product: got %h, expected 001e", p); end
    if (lat != 4) begin n_fail++; $display("FAIL hold_next_latency: got %0d, expected 4", lat); end
    ack_done8();
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] p;
    int lat, bc;
    bit saw_done;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd150; sm8 = 1'b0; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 1;
    if (busy8 !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy_before: got %b, expected 1", busy8); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midcalc_rst_busy: got %b, expected 0", busy8); end
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL midcalc_rst_done: got %b, expected 0", done8); end
    if (prod8 !== 16'h0000) begin n_fail++; $display("FAIL midcalc_rst_product: got %h, expected 0000", prod8); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    n_checks += 1;
    if (saw_done) begin n_fail++; $display("FAIL midcalc_resumed: got activity, expected idle"); end
    run8(8'd6, 8'd7, 1'b0, p, lat, bc);
    n_checks += 2;
    if (p !== 16'd42) begin n_fail++; $display("FAIL midcalc_next_product: got %h, expected 002a", p); end
    if (lat != 4) begin n_fail++; $display("FAIL midcalc_next_latency: got %0d, expected 4", lat); end
    ack_done8();
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd3; sm8 = 1'b0; valid8 = 1'b1; ack8 = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (done8) lat = i;
      else begin @(posedge clk); #1; end
    end
    n_checks += 2;
    if (lat != 3) begin n_fail++; $display("FAIL b2b_first_latency: got %0d, expected 3", lat); end
    if (prod8 !== 16'd6) begin n_fail++; $display("FAIL b2b_first_product: got %h, expected 0006", prod8); end
    a8 = 8'd4; b8 = 8'd5;
    @(posedge clk); #1;
    n_checks += 3;
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_one_cycle: got %b, expected 0", done8); end
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b, expected 0", busy8); end
    if (prod8 !== 16'd6) begin n_fail++; $display("FAIL b2b_idle_product: got %h, expected 0006", prod8); end
    @(posedge clk); #1;
    valid8 = 1'b0;
    n_checks += 1;
    if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b, expected 1", busy8); end
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (done8) lat = i;
      else begin @(posedge clk); #1; end
    end
    n_checks += 2;
    if (lat != 4) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, expected 4", lat); end
    if (prod8 !== 16'd20) begin n_fail++; $display("FAIL b2b_second_product: got %h, expected 0014", prod8); end
    @(posedge clk); #1;
    ack8 = 1'b0;
    n_checks += 1;
    if (done8 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_done_clear: got %b, expected 0", done8); end
  endtask

  task automatic test_regression32();
    logic [31:0] ta, tb, mb;
    logic        tsm;
    logic [63:0] expected;
    int          bl, lat;
    for (int n = 0; n < 1000; n++) begin
      if (n == 0) begin
        ta = 32'h8000_0000; tb = 32'h8000_0000; tsm = 1'b1;
      end else if (n == 1) begin
        ta = 32'hFFFF_FFFF; tb = 32'hFFFF_FFFF; tsm = 1'b0;
      end else begin
        ta = $urandom;
        tb = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) tb = -tb;
        tsm = 1'($urandom_range(0, 1));
      end
      if (tsm) expected = $signed({{32{ta[31]}}, ta}) * $signed({{32{tb[31]}}, tb});
      else     expected = {32'd0, ta} * {32'd0, tb};
      mb = (tsm && tb[31]) ? (~tb + 32'd1) : tb;
      bl = 0;
      for (int k = 0; k < 32; k++) if (mb[k]) bl = k + 1;
      @(negedge clk);
      a32 = ta; b32 = tb; sm32 = tsm; valid32 = 1'b1;
      @(posedge clk); #1;
      valid32 = 1'b0;
      lat = -1;
      for (int i = 0; i < 40 && lat < 0; i++) begin
        if (done32) lat = i;
        else begin @(posedge clk); #1; end
      end
      n_checks += 2;
      if (prod32 !== expected) begin
        n_fail++;
        $display("FAIL r32_product[%0d]: a=%h b=%h s=%b got %h, expected %h", n, ta, tb, tsm, prod32, expected);
      end
      if (lat != bl + 1) begin
        n_fail++;
        $display("FAIL r32_latency[%0d]: b=%h s=%b got %0d, expected %0d", n, tb, tsm, lat, bl + 1);
      end
      ack32 = 1'b1;
      @(posedge clk); #1;
      ack32 = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    valid8 = 1'b0; sm8 = 1'b0; ack8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    valid32 = 1'b0; sm32 = 1'b0; ack32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    test_reset();
    test_unsigned();
    test_boundaries();
    test_signed();
    test_hold();
    test_reset_mid_calc();
    test_back_to_back();
    test_regression32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
